sha256_job_arbiter: RTL and testbench

- Shares one sha256 hash core (start/done, message_addr/output_addr interface) among NUM_REQ requesters.
- Arbitrates round-robin, latches the winner's addresses, pulses the core's start and tracks the core's level `done`.
- Returns a per-requester completion or timeout pulse.
- Sits between software/host request agents and the single hash core; owns no memory port.

---
 rtl/sha256_job_arbiter_pkg.sv | 21 ++
 rtl/sha256_job_arbiter_if.sv | 44 ++++
 rtl/sha256_rr_pick.sv | 37 +++
 rtl/sha256_job_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sha256_job_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_job_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
//   Shared definitions for the sha256 job arbiter:
//   - arb_state_e : arbiter FSM states
//   - SHA_ADDR_W_DEFAULT  : default word-address width of the hash core ports
//   - SHA_TIMEOUT_DEFAULT : default watchdog limit for one job, in cycles
// ---------------------------------------------------------------------------
package sha256_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_RETIRE
   } arb_state_e;

   localparam int SHA_ADDR_W_DEFAULT  = 16;
   localparam int SHA_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/sha256_job_arbiter_if.sv
// ---------------------------------------------------------------------------
// sha256_job_arbiter_if
//   Bundles the requester-side and core-side signals of the arbiter.
//   Requester side : req, req_msg_addr, req_out_addr (in), grant, job_done,
//                    job_err, busy (out)
//   Core side      : core_start, core_message_addr, core_output_addr (out),
//                    core_done (in, level, high while the core is idle)
//   Modports:
//   - slave  : the arbiter's view
//   - master : the environment's view (requesters plus hash core)
//   Per-requester address slice r lives at bits [r*ADDR_W +: ADDR_W].
// ---------------------------------------------------------------------------
interface sha256_job_arbiter_if
   import sha256_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = SHA_ADDR_W_DEFAULT
);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_msg_addr;
   logic [NUM_REQ*ADDR_W-1:0] req_out_addr;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        job_done;
   logic [NUM_REQ-1:0]        job_err;
   logic                      busy;
   logic                      core_start;
   logic [ADDR_W-1:0]         core_message_addr;
   logic [ADDR_W-1:0]         core_output_addr;
   logic                      core_done;

   modport slave (
      input  req, req_msg_addr, req_out_addr, core_done,
      output grant, job_done, job_err, busy,
             core_start, core_message_addr, core_output_addr
   );

   modport master (
      output req, req_msg_addr, req_out_addr, core_done,
      input  grant, job_done, job_err, busy,
             core_start, core_message_addr, core_output_addr
   );

endinterface

// File: rtl/sha256_rr_pick.sv
// ---------------------------------------------------------------------------
// sha256_rr_pick
//   Combinational round-robin picker. Searches req starting at ptr+1
//   (modulo NUM_REQ) and returns the first asserted requester.
//   Ports:
//   - req    : request vector
//   - ptr    : index of the most recently served requester
//   - winner : one-hot winner (all zero when nothing is requested)
//   - valid  : at least one request is asserted
// ---------------------------------------------------------------------------
module sha256_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      // Offset 1 first so the last-served requester has lowest priority.
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha256_job_arbiter.sv
// ---------------------------------------------------------------------------
// sha256_job_arbiter
//   Shares one sha256 hash core among NUM_REQ requesters. Picks a requester
//   round-robin, latches its addresses onto the core ports, pulses
//   core_start, follows core_done low then high, and returns a one-cycle
//   job_done (success) or job_err (watchdog expiry) to that requester.
//   Ports:
//   - clk, reset_n : clock, asynchronous active-low reset
//   - bus          : sha256_job_arbiter_if.slave (requester + core signals)
//   - job_count, err_count : saturating statistics, present only when the
//                    SHA_ARB_STATS_EN macro is defined
// ---------------------------------------------------------------------------
module sha256_job_arbiter
   import sha256_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = SHA_TIMEOUT_DEFAULT,
   parameter int ADDR_W         = SHA_ADDR_W_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   sha256_job_arbiter_if.slave bus
`ifdef SHA_ARB_STATS_EN
   ,
   output logic [31:0] job_count,
   output logic [15:0] err_count
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] job_done_q, job_done_d;
   logic [NUM_REQ-1:0] job_err_q, job_err_d;
   logic               core_start_q, core_start_d;
   logic [ADDR_W-1:0]  msg_addr_q, msg_addr_d;
   logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   win_q, win_d;
   logic [WD_W-1:0]    wd_q, wd_d;

   logic [NUM_REQ-1:0] pick_oh;
   logic               pick_valid;
   logic [PTR_W-1:0]   pick_idx;
   logic [ADDR_W-1:0]  msg_arr [NUM_REQ];
   logic [ADDR_W-1:0]  out_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign msg_arr[gi] = bus.req_msg_addr[gi*ADDR_W +: ADDR_W];
      assign out_arr[gi] = bus.req_out_addr[gi*ADDR_W +: ADDR_W];
   end

   sha256_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (pick_oh),
      .valid  (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) pick_idx = PTR_W'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      job_done_d   = '0;
      job_err_d    = '0;
      core_start_d = 1'b0;
      msg_addr_d   = msg_addr_q;
      out_addr_d   = out_addr_q;
      ptr_d        = ptr_q;
      win_d        = win_q;
      wd_d         = wd_q;
      case (state_q)
         ST_IDLE: begin
            // A low core_done here means someone else is driving the core.
            if (pick_valid && bus.core_done) begin
               grant_d      = pick_oh;
               win_d        = pick_idx;
               msg_addr_d   = msg_arr[pick_idx];
               out_addr_d   = out_arr[pick_idx];
               core_start_d = 1'b1;
               state_d      = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wd_d    = '0;
            state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW, ST_WAIT_HIGH: begin
            wd_d = wd_q + 1'b1;
            // Completion is checked before expiry so a simultaneous
            // done-rise and timeout retires as a success.
            if (state_q == ST_WAIT_HIGH && bus.core_done) begin
               grant_d    = '0;
               job_done_d = grant_q;
               ptr_d      = win_q;
               state_d    = ST_RETIRE;
            end else if (wd_q == WD_LAST) begin
               grant_d   = '0;
               job_err_d = grant_q;
               ptr_d     = win_q;
               state_d   = ST_IDLE;
            end else if (state_q == ST_WAIT_LOW && !bus.core_done) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_RETIRE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         job_done_q   <= '0;
         job_err_q    <= '0;
         core_start_q <= 1'b0;
         msg_addr_q   <= '0;
         out_addr_q   <= '0;
         ptr_q        <= PTR_RST;
         win_q        <= '0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         job_done_q   <= job_done_d;
         job_err_q    <= job_err_d;
         core_start_q <= core_start_d;
         msg_addr_q   <= msg_addr_d;
         out_addr_q   <= out_addr_d;
         ptr_q        <= ptr_d;
         win_q        <= win_d;
         wd_q         <= wd_d;
      end
   end

   assign bus.grant             = grant_q;
   assign bus.job_done          = job_done_q;
   assign bus.job_err           = job_err_q;
   assign bus.busy              = (state_q != ST_IDLE);
   assign bus.core_start        = core_start_q;
   assign bus.core_message_addr = msg_addr_q;
   assign bus.core_output_addr  = out_addr_q;

`ifdef SHA_ARB_STATS_EN
   logic [31:0] job_count_q, job_count_d;
   logic [15:0] err_count_q, err_count_d;

   always_comb begin
      job_count_d = job_count_q;
      err_count_d = err_count_q;
      if ((|job_done_q) && (job_count_q != '1)) job_count_d = job_count_q + 32'd1;
      if ((|job_err_q) && (err_count_q != '1))  err_count_d = err_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         job_count_q <= '0;
         err_count_q <= '0;
      end else begin
         job_count_q <= job_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign job_count = job_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sha256_job_arbiter
//   Scoreboard bench for sha256_job_arbiter (4 requesters, 16-bit addresses,
//   64-cycle watchdog). Stimulus pushes the expected core launches and
//   completion pulses into queues; a monitor on the falling edge pops and
//   compares whenever the DUT shows core_start or a job pulse. A small core
//   model drops done one cycle after the start edge and raises it again
//   after a programmable latency, or never (hang). Define SHA_ARB_STATS_EN
//   to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_sha256_job_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int TO = 64;

   typedef struct packed {
      logic [AW-1:0] msg;
      logic [AW-1:0] outa;
      logic [NR-1:0] grant;
   } start_exp_t;

   typedef struct packed {
      logic          err;
      logic [NR-1:0] vec;
   } job_exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sha256_job_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

`ifdef SHA_ARB_STATS_EN
   logic [31:0] job_count;
   logic [15:0] err_count;
`endif

   sha256_job_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef SHA_ARB_STATS_EN
      ,
      .job_count (job_count),
      .err_count (err_count)
`endif
   );

   // ---------------- core model ----------------
   bit core_running = 1'b0;
   bit core_hang    = 1'b0;
   bit core_kill    = 1'b0;
   bit ext_hold     = 1'b0;
   int core_lat     = 10;
   int core_cnt     = 0;

   always @(posedge clk) begin
      if (bus.core_start) begin
         core_running <= 1'b1;
         core_cnt     <= core_lat;
      end else if (core_kill) begin
         core_running <= 1'b0;
      end else if (core_running && !core_hang) begin
         if (core_cnt > 0) core_cnt <= core_cnt - 1;
         else              core_running <= 1'b0;
      end
   end

   assign bus.core_done = !core_running && !ext_hold;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int n_ev     = 0;
   int n_start  = 0;
   int cyc      = 0;
   int start_cyc = 0;
   int done_cnt [NR];
   start_exp_t start_q [$];
   job_exp_t   job_q [$];
   start_exp_t se;
   job_exp_t   je;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [AW-1:0] msg_of(input int i);
      return AW'(i * 4096);
   endfunction

   function automatic logic [AW-1:0] out_of(input int i);
      return msg_of(i) + 16'h0100;
   endfunction

   initial begin
      for (int r = 0; r < NR; r++) done_cnt[r] = 0;
   end

   always @(negedge clk) begin
      cyc++;
      if (bus.core_start === 1'b1) begin
         n_start++;
         start_cyc = cyc;
         if (start_q.size() == 0) begin
            check("unexpected_start", 64'(bus.grant), 64'd0);
         end else begin
            se = start_q.pop_front();
            check("start_msg_addr", 64'(bus.core_message_addr), 64'(se.msg));
            check("start_out_addr", 64'(bus.core_output_addr), 64'(se.outa));
            check("start_grant", 64'(bus.grant), 64'(se.grant));
            $display("start: grant=%b msg=%h out=%h", bus.grant,
                     bus.core_message_addr, bus.core_output_addr);
         end
      end
      if ((bus.job_done | bus.job_err) !== '0) begin
         n_ev++;
         for (int r = 0; r < NR; r++) if (bus.job_done[r]) done_cnt[r]++;
         if (job_q.size() == 0) begin
            check("unexpected_pulse", 64'({bus.job_err, bus.job_done}), 64'd0);
         end else begin
            je = job_q.pop_front();
            check("pulse", 64'({bus.job_err, bus.job_done}),
                  je.err ? 64'({je.vec, 4'b0000}) : 64'({4'b0000, je.vec}));
            check("grant_clear_at_pulse", 64'(bus.grant), 64'd0);
            if (je.err)
               check("err_latency_near_timeout",
                     64'((cyc - start_cyc >= TO - 1) && (cyc - start_cyc <= TO + 2)), 64'd1);
            $display("job: done=%b err=%b cycles_since_start=%0d", bus.job_done,
                     bus.job_err, cyc - start_cyc);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ev(input int target, input int budget, input string what);
      int k = 0;
      while (n_ev < target && k < budget) begin
         tick();
         k++;
      end
      check({what, "_event_seen"}, 64'(n_ev >= target), 64'd1);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_grant", 64'(bus.grant), 64'd0);
      check("rst_pulses", 64'({bus.job_err, bus.job_done}), 64'd0);
      check("rst_start_busy", 64'({bus.core_start, bus.busy}), 64'd0);
      check("rst_addrs", 64'({bus.core_message_addr, bus.core_output_addr}), 64'd0);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic push_job(input int idx, input bit err);
      start_q.push_back('{msg: msg_of(idx), outa: out_of(idx), grant: NR'(1 << idx)});
      job_q.push_back('{err: err, vec: NR'(1 << idx)});
   endtask

   task automatic run_one(input logic [NR-1:0] rv, input int idx, input bit hang,
                          input int lat);
      int tgt;
      core_lat  = lat;
      core_hang = hang;
      push_job(idx, hang);
      tgt = n_ev + 1;
      bus.req = rv;
      wait_ev(tgt, TO + lat + 20, "job");
      bus.req = '0;
      if (hang) begin
         core_kill = 1'b1;
         tick();
         core_kill = 1'b0;
         core_hang = 1'b0;
      end
      repeat (2) tick();
      check("busy_after_job", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int tgt, s0, k, bad;
      int snap [NR];
      bus.req = '0;
      for (int r = 0; r < NR; r++) begin
         bus.req_msg_addr[r*AW +: AW] = msg_of(r);
         bus.req_out_addr[r*AW +: AW] = out_of(r);
      end

      // Reset state, then a single job from requester 0 (0000/0100).
      apply_reset();
      run_one(4'b0001, 0, 1'b0, 40);

      // All four requesting from reset: order 0,1,2,3,0,1,2,3.
      apply_reset();
      for (int r = 0; r < NR; r++) snap[r] = done_cnt[r];
      core_lat = 5;
      for (int j = 0; j < 8; j++) push_job(j % NR, 1'b0);
      tgt = n_ev + 8;
      bus.req = 4'b1111;
      wait_ev(tgt, 8 * 30, "rr8");
      bus.req = '0;
      for (int r = 0; r < NR; r++) check("rr_two_jobs_each", 64'(done_cnt[r] - snap[r]), 64'd2);
      repeat (3) tick();

      // Hung core: requester 0 times out, then requester 1 is served.
      core_hang = 1'b1;
      push_job(0, 1'b1);
      push_job(1, 1'b0);
      tgt = n_ev + 1;
      bus.req = 4'b0011;
      wait_ev(tgt, TO + 20, "timeout");
      core_kill = 1'b1;
      tick();
      core_kill = 1'b0;
      core_hang = 1'b0;
      tgt = n_ev + 1;
      wait_ev(tgt, 40, "after_timeout");
      bus.req = '0;
      repeat (2) tick();

      // Core held busy externally: no launch until done is released.
      ext_hold = 1'b1;
      bus.req  = 4'b0010;
      bad = 0;
      repeat (10) begin
         tick();
         if (bus.core_start !== 1'b0 || bus.grant !== '0) bad++;
      end
      check("held_no_start", 64'(bad), 64'd0);
      push_job(1, 1'b0);
      s0 = n_start;
      ext_hold = 1'b0;
      k = 0;
      while (n_start == s0 && k < 4) begin
         tick();
         k++;
      end
      check("start_within_2", 64'((n_start > s0) && (k <= 2)), 64'd1);
      tgt = n_ev + 1;
      wait_ev(tgt, 40, "after_hold");
      bus.req = '0;
      repeat (2) tick();

      // Reset while waiting on the core: outputs clear, no pulse.
      core_lat = 30;
      start_q.push_back('{msg: msg_of(2), outa: out_of(2), grant: 4'b0100});
      s0 = n_start;
      bus.req = 4'b0100;
      k = 0;
      while (n_start == s0 && k < 10) begin
         tick();
         k++;
      end
      repeat (5) tick();
      check("busy_mid_job", 64'({bus.busy, bus.grant}), 64'({1'b1, 4'b0100}));
      reset_n = 1'b0;
      #1;
      check("midrst_grant_busy", 64'({bus.grant, bus.busy}), 64'd0);
      check("midrst_pulses", 64'({bus.job_err, bus.job_done, bus.core_start}), 64'd0);
      check("midrst_addrs", 64'({bus.core_message_addr, bus.core_output_addr}), 64'd0);
      bus.req = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      k = 0;
      while (!bus.core_done && k < 60) begin
         tick();
         k++;
      end
      check("core_idle_after_reset", 64'(bus.core_done), 64'd1);
      run_one(4'b1101, 0, 1'b0, 5);

      // Three successes and one timeout from a fresh reset.
      apply_reset();
      run_one(4'b0001, 0, 1'b0, 5);
      run_one(4'b0010, 1, 1'b0, 5);
      run_one(4'b0100, 2, 1'b0, 5);
      run_one(4'b1000, 3, 1'b1, 5);
`ifdef SHA_ARB_STATS_EN
      check("job_count", 64'(job_count), 64'd3);
      check("err_count", 64'(err_count), 64'd1);
`endif

      repeat (3) tick();
      check("start_queue_drained", 64'(start_q.size()), 64'd0);
      check("job_queue_drained", 64'(job_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
